// File: rtl/riscv_wb_pkg.sv
// Shared encodings for the writeback stage: result-source selects, load funct3 codes and the
// FSM state encoding.
package riscv_wb_pkg;

  // Result source select carried from MEM; 2'b11 falls through to the ALU path.
  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  // Load size/sign encodings (funct3 of the load opcode).
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Writeback FSM state encoding.
  typedef logic [1:0] wb_state_t;
  localparam wb_state_t ST_IDLE      = 2'd0;
  localparam wb_state_t ST_WAIT_LOAD = 2'd1;
  localparam wb_state_t ST_WRITE     = 2'd2;

endpackage

// File: rtl/load_formatter.sv
// Combinational load-data formatter: picks the byte/half addressed by addr_lo out of the raw
// aligned word and sign- or zero-extends it according to funct3.
module load_formatter
  import riscv_wb_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection; halves use only addr_lo[1], the low bit is ignored.
  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extension by size/sign; unknown encodings load the whole word.
  always_comb begin
    result = rdata;
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  result = {24'h0, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  result = {16'h0, half_sel};
      F3_LW:   result = rdata;
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: one-entry stage register sequenced by an IDLE/WAIT_LOAD/WRITE FSM, driving
// the register-file write port. Loads hold intake until the data response arrives.
// Optional feature macro WB_RETIRE_CNT_EN adds the instret retired-instruction counter output.
module wb_stage
  import riscv_wb_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned RETIRE_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_we,
  input  logic [4:0]          in_rd,
  input  logic [1:0]          in_result_src,
  input  logic [XLEN-1:0]     in_alu_result,
  input  logic [XLEN-1:0]     in_pc_plus4,
  input  logic [2:0]          in_funct3,
  input  logic [1:0]          in_addr_lo,
  input  logic                dmem_rsp_valid,
  input  logic [XLEN-1:0]     dmem_rdata,
  output logic                WE3,
  output logic [XLEN-1:0]     WD3,
  output logic [4:0]          rd,
  output logic                retire
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [RETIRE_W-1:0] instret
`endif
);

  if (XLEN != 32 || RETIRE_W == 0) begin : g_bad_cfg
    $error("wb_stage: only XLEN=32 and RETIRE_W>0 are supported");
  end

  wb_state_t       state_q, state_d;
  logic            stg_we_q, stg_we_d;
  logic [4:0]      stg_rd_q, stg_rd_d;
  logic [2:0]      stg_funct3_q, stg_funct3_d;
  logic [1:0]      stg_addr_lo_q, stg_addr_lo_d;
  logic [XLEN-1:0] stg_result_q, stg_result_d;
  logic            we3_q, we3_d;
  logic [XLEN-1:0] wd3_q, wd3_d;
  logic [4:0]      wr_rd_q, wr_rd_d;
  logic            retire_q, retire_d;
  logic [XLEN-1:0] fmt_result;
  logic            capture;

  load_formatter u_load_formatter (
    .rdata   (dmem_rdata),
    .funct3  (stg_funct3_q),
    .addr_lo (stg_addr_lo_q),
    .result  (fmt_result)
  );

  assign in_ready = (state_q != ST_WAIT_LOAD);
  assign capture  = in_valid && in_ready;

  // FSM next state, stage-register update and registered write-port outputs.
  always_comb begin
    state_d       = state_q;
    stg_we_d      = stg_we_q;
    stg_rd_d      = stg_rd_q;
    stg_funct3_d  = stg_funct3_q;
    stg_addr_lo_d = stg_addr_lo_q;
    stg_result_d  = stg_result_q;
    case (state_q)
      ST_IDLE, ST_WRITE: begin
        if (capture) begin
          state_d       = (in_result_src == RES_LOAD) ? ST_WAIT_LOAD : ST_WRITE;
          stg_we_d      = in_we;
          stg_rd_d      = in_rd;
          stg_funct3_d  = in_funct3;
          stg_addr_lo_d = in_addr_lo;
          // Non-load result is resolved now; a load overwrites it on the response.
          stg_result_d  = (in_result_src == RES_PC4) ? in_pc_plus4 : in_alu_result;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_LOAD: begin
        if (dmem_rsp_valid) begin
          state_d      = ST_WRITE;
          stg_result_d = fmt_result;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are computed from the next stage contents so they line up with state WRITE.
    retire_d = (state_d == ST_WRITE);
    we3_d    = retire_d && stg_we_d && (stg_rd_d != 5'd0);
    wd3_d    = wd3_q;
    wr_rd_d  = wr_rd_q;
    if (we3_d) begin
      wd3_d   = stg_result_d;
      wr_rd_d = stg_rd_d;
    end
  end

  // State and stage register with synchronous reset; a pending load is simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      stg_we_q      <= 1'b0;
      stg_rd_q      <= 5'd0;
      stg_funct3_q  <= 3'd0;
      stg_addr_lo_q <= 2'd0;
      stg_result_q  <= '0;
      we3_q         <= 1'b0;
      wd3_q         <= '0;
      wr_rd_q       <= 5'd0;
      retire_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      stg_we_q      <= stg_we_d;
      stg_rd_q      <= stg_rd_d;
      stg_funct3_q  <= stg_funct3_d;
      stg_addr_lo_q <= stg_addr_lo_d;
      stg_result_q  <= stg_result_d;
      we3_q         <= we3_d;
      wd3_q         <= wd3_d;
      wr_rd_q       <= wr_rd_d;
      retire_q      <= retire_d;
    end
  end

  assign WE3    = we3_q;
  assign WD3    = wd3_q;
  assign rd     = wr_rd_q;
  assign retire = retire_q;

`ifdef WB_RETIRE_CNT_EN
  logic [RETIRE_W-1:0] instret_q, instret_d;

  // Retired-instruction counter; wraps naturally at all-ones.
  always_comb begin
    instret_d = retire_q ? instret_q + 1'b1 : instret_q;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage. Define WB_RETIRE_CNT_EN to also check instret.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_we;
  logic [4:0]  in_rd;
  logic [1:0]  in_result_src;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc_plus4;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rdata;
  logic        WE3;
  logic [31:0] WD3;
  logic [4:0]  rd;
  logic        retire;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] instret;
`endif

  int unsigned n_total  = 0;
  int unsigned n_passed = 0;
  int unsigned n_retire = 0;

  wb_stage #(.XLEN(32), .RETIRE_W(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_we          (in_we),
    .in_rd          (in_rd),
    .in_result_src  (in_result_src),
    .in_alu_result  (in_alu_result),
    .in_pc_plus4    (in_pc_plus4),
    .in_funct3      (in_funct3),
    .in_addr_lo     (in_addr_lo),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rdata     (dmem_rdata),
    .WE3            (WE3),
    .WD3            (WD3),
    .rd             (rd),
    .retire         (retire)
`ifdef WB_RETIRE_CNT_EN
    ,
    .instret        (instret)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic we, input logic [4:0] r, input logic [1:0] src,
                       input logic [31:0] alu, input logic [31:0] pc4,
                       input logic [2:0] f3, input logic [1:0] alo);
    in_valid      = 1'b1;
    in_we         = we;
    in_rd         = r;
    in_result_src = src;
    in_alu_result = alu;
    in_pc_plus4   = pc4;
    in_funct3     = f3;
    in_addr_lo    = alo;
  endtask

  // Capture a load, stall for gap cycles, respond, then check the write.
  task automatic do_load(input string tag, input logic [4:0] r, input logic [2:0] f3,
                         input logic [1:0] alo, input logic [31:0] word, input int gap,
                         input logic [31:0] exp_wd);
    offer(1'b1, r, 2'b01, 32'h0000_0000, 32'h0, f3, alo);
    tick();
    in_valid = 1'b0;
    check({tag, "_ready0"}, 64'(in_ready), 64'd0);
    check({tag, "_we3_wait"}, 64'(WE3), 64'd0);
    for (int i = 0; i < gap; i++) begin
      tick();
      check({tag, "_stall_ready"}, 64'(in_ready), 64'd0);
    end
    dmem_rsp_valid = 1'b1;
    dmem_rdata     = word;
    tick();
    dmem_rsp_valid = 1'b0;
    dmem_rdata     = 32'hDEAD_BEEF;
    n_retire++;
    check({tag, "_we3"}, 64'(WE3), 64'd1);
    check({tag, "_wd3"}, 64'(WD3), 64'(exp_wd));
    check({tag, "_rd"}, 64'(rd), 64'(r));
  endtask

  initial begin
    rst            = 1'b1;
    in_valid       = 1'b0;
    in_we          = 1'b0;
    in_rd          = 5'd0;
    in_result_src  = 2'b00;
    in_alu_result  = 32'h0;
    in_pc_plus4    = 32'h0;
    in_funct3      = 3'b000;
    in_addr_lo     = 2'b00;
    dmem_rsp_valid = 1'b0;
    dmem_rdata     = 32'h0;
    tick();
    tick();
    check("rst_we3", 64'(WE3), 64'd0);
    check("rst_wd3", 64'(WD3), 64'd0);
    check("rst_rd", 64'(rd), 64'd0);
    check("rst_retire", 64'(retire), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
`ifdef WB_RETIRE_CNT_EN
    check("rst_instret", instret, 64'd0);
`endif
    rst = 1'b0;
    tick();

    // ALU write, exactly one cycle of WE3.
    offer(1'b1, 5'd5, 2'b00, 32'h0000_1234, 32'h0, 3'b000, 2'b00);
    tick();
    in_valid = 1'b0;
    n_retire++;
    check("alu_we3", 64'(WE3), 64'd1);
    check("alu_rd", 64'(rd), 64'd5);
    check("alu_wd3", 64'(WD3), 64'h1234);
    check("alu_retire", 64'(retire), 64'd1);
    tick();
    check("alu_we3_off", 64'(WE3), 64'd0);
    check("alu_retire_off", 64'(retire), 64'd0);
    check("alu_wd3_hold", 64'(WD3), 64'h1234);

    // Byte loads, signed and unsigned, from the top byte lane.
    do_load("lb", 5'd7, 3'b000, 2'd3, 32'h80FF_7F01, 0, 32'hFFFF_FF80);
    do_load("lbu", 5'd8, 3'b100, 2'd3, 32'h80FF_7F01, 1, 32'h0000_0080);
    do_load("lb1", 5'd6, 3'b000, 2'd1, 32'h80FF_7F01, 0, 32'h0000_007F);
    // Halfword load with a 4-cycle stall.
    do_load("lh", 5'd9, 3'b001, 2'd2, 32'h8001_0000, 4, 32'hFFFF_8001);
    do_load("lhu", 5'd4, 3'b101, 2'd3, 32'h8001_0000, 0, 32'h0000_8001);
    do_load("lw", 5'd3, 3'b010, 2'd2, 32'h1234_5678, 0, 32'h1234_5678);

    // rd=0: no write but still retires.
    offer(1'b1, 5'd0, 2'b00, 32'h0000_DEAD, 32'h0, 3'b000, 2'b00);
    tick();
    n_retire++;
    check("rd0_we3", 64'(WE3), 64'd0);
    check("rd0_retire", 64'(retire), 64'd1);
    check("rd0_wd3_hold", 64'(WD3), 64'h1234_5678);
    check("rd0_rd_hold", 64'(rd), 64'd3);
    // JAL link value, captured straight out of WRITE.
    offer(1'b1, 5'd1, 2'b10, 32'h0000_0999, 32'h0000_0104, 3'b000, 2'b00);
    tick();
    in_valid = 1'b0;
    n_retire++;
    check("jal_we3", 64'(WE3), 64'd1);
    check("jal_wd3", 64'(WD3), 64'h104);
    check("jal_rd", 64'(rd), 64'd1);
    tick();

    // Back-to-back ALU ops, including src=11 treated as ALU.
    offer(1'b1, 5'd10, 2'b00, 32'h0000_000A, 32'h0, 3'b000, 2'b00);
    tick();
    check("b2b0_we3", 64'(WE3), 64'd1);
    check("b2b0_wd3", 64'(WD3), 64'hA);
    offer(1'b1, 5'd11, 2'b11, 32'h0000_000B, 32'h0000_0FFF, 3'b000, 2'b00);
    tick();
    check("b2b1_we3", 64'(WE3), 64'd1);
    check("b2b1_wd3", 64'(WD3), 64'hB);
    check("b2b1_ready", 64'(in_ready), 64'd1);
    offer(1'b1, 5'd12, 2'b00, 32'h0000_000C, 32'h0, 3'b000, 2'b00);
    tick();
    n_retire += 3;
    check("b2b2_we3", 64'(WE3), 64'd1);
    check("b2b2_wd3", 64'(WD3), 64'hC);
    check("b2b2_rd", 64'(rd), 64'd12);
    in_valid       = 1'b0;
    dmem_rsp_valid = 1'b1;
    dmem_rdata     = 32'h5555_5555;
    tick();
    check("stray0_we3", 64'(WE3), 64'd0);
    check("stray0_ready", 64'(in_ready), 64'd1);
    tick();
    dmem_rsp_valid = 1'b0;
    check("stray1_we3", 64'(WE3), 64'd0);
    check("stray1_retire", 64'(retire), 64'd0);
    check("stray1_wd3", 64'(WD3), 64'hC);
`ifdef WB_RETIRE_CNT_EN
    check("instret_count", instret, 64'(n_retire));
`endif

    // Reset while a load is pending; the late response must not write.
    offer(1'b1, 5'd20, 2'b01, 32'h0, 32'h0, 3'b010, 2'b00);
    tick();
    in_valid = 1'b0;
    check("rstw_ready0", 64'(in_ready), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstw_ready", 64'(in_ready), 64'd1);
    check("rstw_wd3", 64'(WD3), 64'd0);
    check("rstw_rd", 64'(rd), 64'd0);
`ifdef WB_RETIRE_CNT_EN
    check("rstw_instret", instret, 64'd0);
`endif
    dmem_rsp_valid = 1'b1;
    dmem_rdata     = 32'hCAFE_F00D;
    tick();
    dmem_rsp_valid = 1'b0;
    check("rstw_we3", 64'(WE3), 64'd0);
    check("rstw_retire", 64'(retire), 64'd0);
    tick();
    check("rstw_we3_late", 64'(WE3), 64'd0);
    check("rstw_wd3_late", 64'(WD3), 64'd0);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
